pcm_fifo_player: RTL

PCM_FIFO_PLAYER -- requirements
Module: pcm_fifo_player

---
 rtl/pcm_audio_pkg.sv | 17 +
 rtl/pcm_pwm_dac.sv | 36 +++
 rtl/pcm_fifo_player.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pcm_audio_pkg.sv
// Shared definitions for the FIFO-fed PWM audio player.
package pcm_audio_pkg;

  localparam int unsigned DBITS_DEFAULT           = 8;
  localparam int unsigned CLKS_PER_SAMPLE_DEFAULT = 3125;
  localparam int unsigned RD_LAT_DEFAULT          = 2;

  // Half-scale code for the default width; used as the silence level
  localparam logic [DBITS_DEFAULT-1:0] MIDSCALE = DBITS_DEFAULT'(1) << (DBITS_DEFAULT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2
  } pcm_state_e;

endpackage

// File: rtl/pcm_pwm_dac.sv
// PWM DAC: free-running counter, sample reload only at period wrap, registered compare.
module pcm_pwm_dac
  import pcm_audio_pkg::*;
#(
  parameter int unsigned DBITS = DBITS_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DBITS-1:0] pending,
  output logic [DBITS-1:0] sample,
  output logic             pwm_out
);

  localparam logic [DBITS-1:0] MID = DBITS'(1) << (DBITS - 1);

  logic [DBITS-1:0] pwm_cnt;

  // Counter advances only while enabled; new sample latched as the counter wraps to 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      sample  <= MID;
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= enable && (pwm_cnt < sample);
      if (enable) begin
        pwm_cnt <= pwm_cnt + DBITS'(1);
        if (pwm_cnt == '1) begin
          sample <= pending;
        end
      end
    end
  end

endmodule

// File: rtl/pcm_fifo_player.sv
// Pulls one sample per audio period from a FIFO and plays it through a PWM DAC.
module pcm_fifo_player
  import pcm_audio_pkg::*;
#(
  parameter int unsigned DBITS           = DBITS_DEFAULT,
  parameter int unsigned CLKS_PER_SAMPLE = CLKS_PER_SAMPLE_DEFAULT,
  parameter int unsigned RD_LAT          = RD_LAT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [DBITS-1:0] fifo_dout,
  output logic             fifo_rd,
  output logic             pwm_out,
  output logic [DBITS-1:0] sample,
  output logic             underrun,
  output logic [7:0]       underrun_cnt,
  output logic             busy
);

  localparam int unsigned DIV_W = $clog2(CLKS_PER_SAMPLE);
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);
  localparam logic [DBITS-1:0] MID = DBITS'(1) << (DBITS - 1);

  // A sample period must cover one PWM period and a full read, so ticks only land in IDLE
  if ((CLKS_PER_SAMPLE < 2**DBITS) || (CLKS_PER_SAMPLE < RD_LAT + 3) || (RD_LAT < 1)) begin : g_bad_params
    $error("pcm_fifo_player: illegal CLKS_PER_SAMPLE/RD_LAT/DBITS combination");
  end

  pcm_state_e       state, state_nxt;
  logic [DIV_W-1:0] div;
  logic [LAT_W-1:0] lat;
  logic [DBITS-1:0] pending;
  logic             tick_c;
  logic             load_c;
  logic             underrun_c;

  assign tick_c = enable && (div == DIV_W'(CLKS_PER_SAMPLE - 1));

  // Sample-rate divider, parked at 0 while disabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (!enable || tick_c) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a tick either starts a read or reports an underrun; disable aborts anything in flight
  always_comb begin
    state_nxt  = state;
    load_c     = 1'b0;
    underrun_c = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick_c) begin
            if (fifo_empty) begin
              underrun_c = 1'b1;
            end else begin
              state_nxt = ST_READ;
            end
          end
        end
        ST_READ: state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (lat == LAT_W'(RD_LAT - 1)) begin
            load_c    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Clocks spent in WAIT since the read strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat <= '0;
    end else if (state == ST_WAIT) begin
      lat <= lat + LAT_W'(1);
    end else begin
      lat <= '0;
    end
  end

  // Registered strobes, status, underrun accounting and the next sample to play
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_rd      <= 1'b0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
      pending      <= MID;
    end else begin
      fifo_rd  <= (state_nxt == ST_READ);
      busy     <= (state_nxt != ST_IDLE);
      underrun <= underrun_c;
      if (underrun_c && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
      if (underrun_c) begin
        pending <= MID;
      end else if (load_c) begin
        pending <= fifo_dout;
      end
    end
  end

  pcm_pwm_dac #(
    .DBITS (DBITS)
  ) u_dac (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .pending (pending),
    .sample  (sample),
    .pwm_out (pwm_out)
  );

endmodule
